// File: rtl/periph_pkg.sv
// Shared constants for the DueProLogic board peripherals. Both the switch
// input controller and the LED output controller pull their defaults from here,
// so the board pin counts are defined in one place.
package periph_pkg;

  // 1 ms of stable input at the 50 MHz board clock.
  localparam int DEFAULT_DEBOUNCE_CNT = 50000;

  // Pin counts on the board headers.
  localparam int BOARD_N_SWITCHES = 8;
  localparam int BOARD_N_LEDS     = 8;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, debounce counter, accepted level and
// single-cycle press/release pulses.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en         low holds counter, level and pulses at 0 (synchronizer keeps running)
//   pin_n      raw active-low pin, asynchronous to clk
//   level      debounced active-high level
//   press      one-cycle pulse when level goes 0->1
//   rel_pulse  one-cycle pulse when level goes 1->0
module debounce_bit #(
  parameter int DEBOUNCE_CNT = 50000,
  parameter int CNT_W        = $clog2(DEBOUNCE_CNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pin_n,
  output logic level,
  output logic press,
  output logic rel_pulse
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CNT - 1);

  logic             meta_reg;
  logic             sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             stable_reg;
  logic             press_reg;
  logic             rel_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
      rel_reg    <= 1'b0;
    end else begin
      // Invert before the first flop so everything downstream is active-high.
      meta_reg <= ~pin_n;
      sync_reg <= meta_reg;

      if (!en) begin
        cnt_reg    <= '0;
        stable_reg <= 1'b0;
        press_reg  <= 1'b0;
        rel_reg    <= 1'b0;
      end else begin
        press_reg <= 1'b0;
        rel_reg   <= 1'b0;
        if (sync_reg == stable_reg) begin
          // Any return to the accepted level restarts the count.
          cnt_reg <= '0;
        end else if (cnt_reg == LAST_CNT) begin
          stable_reg <= sync_reg;
          cnt_reg    <= '0;
          // Pulses are registered alongside the level so they line up with it.
          press_reg  <= sync_reg;
          rel_reg    <= ~sync_reg;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign level     = stable_reg;
  assign press     = press_reg;
  assign rel_pulse = rel_reg;

endmodule

// File: rtl/switch_controller.sv
// Switch/push-button input peripheral. Debounces N active-low pins and presents
// clean levels, press/release pulses, and a sticky press-event register that the
// host clears with event_ack.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             block enable; low forces all state and outputs to idle
//   in_from_pin    raw active-low pins
//   state_out      debounced active-high levels
//   press_pulse    one-cycle pulses on accepted presses
//   release_pulse  one-cycle pulses on accepted releases
//   event_valid    high while event_data is non-zero
//   event_data     sticky OR of press pulses since the last ack
//   event_ack      clears event_data (presses in the same cycle are kept)
module switch_controller
  import periph_pkg::*;
#(
  parameter int N_INPUTS     = BOARD_N_SWITCHES,
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT,
  parameter int CNT_W        = $clog2(DEBOUNCE_CNT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_INPUTS-1:0] in_from_pin,
  output logic [N_INPUTS-1:0] state_out,
  output logic [N_INPUTS-1:0] press_pulse,
  output logic [N_INPUTS-1:0] release_pulse,
  output logic                event_valid,
  output logic [N_INPUTS-1:0] event_data,
  input  logic                event_ack
);

  logic [N_INPUTS-1:0] event_next;

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pin_n    (in_from_pin[gi]),
      .level    (state_out[gi]),
      .press    (press_pulse[gi]),
      .rel_pulse(release_pulse[gi])
    );
  end

  // Ack clears first, then new presses are OR-ed in, so a press that lands in
  // the ack cycle survives.
  assign event_next = (event_ack ? '0 : event_data) | press_pulse;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      event_data  <= '0;
      event_valid <= 1'b0;
    end else begin
      event_data  <= event_next;
      event_valid <= |event_next;
    end
  end

endmodule

// File: doc/switch_controller.md
# switch_controller

Input-side peripheral for the DueProLogic board: samples N active-low push-button/switch pins, synchronizes and debounces each bit, and presents clean active-high levels, single-cycle press/release pulses, and a sticky press-event register with a valid/ack handshake for the host-side logic. It is the read counterpart of the LED output controller and sits between the board pins and the command/control logic.

## Interface
Parameters:
- N_INPUTS, 8: number of input pins.
- DEBOUNCE_CNT, 50000: consecutive stable cycles required to accept a change (1 ms at 50 MHz); must be ≥1.
- CNT_W, $clog2(DEBOUNCE_CNT+1): counter width, derived, not overridden.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low forces outputs and state to idle.
- in_from_pin  in  N_INPUTS  raw pin levels, active-low (0 = pressed), asynchronous to clk.
- state_out  out  N_INPUTS  debounced level, active-high (1 = pressed).
- press_pulse  out  N_INPUTS  one-cycle pulse per bit on accepted 0→1 of state_out.
- release_pulse  out  N_INPUTS  one-cycle pulse per bit on accepted 1→0 of state_out.
- event_valid  out  1  high while event_data ≠ 0.
- event_data  out  N_INPUTS  sticky OR of press_pulse since last ack.
- event_ack  in  1  consumer acknowledge; clears event_data.

## Operation
- Per bit: 2-flop synchronizer on ~in_from_pin → sync_q (inversion before the first flop).
- Debounce per bit: if sync_q == stable, counter ← 0; else if counter == DEBOUNCE_CNT-1, stable ← sync_q and counter ← 0; else counter ← counter+1. Any glitch back to stable value restarts the count.
- state_out = stable (registered). press_pulse/release_pulse registered in the same cycle stable changes: asserted the cycle state_out first shows the new value, exactly one cycle.
- event_data next = (event_ack ? 0 : event_data) | press_pulse. Ack is honored whether or not event_valid is high; presses arriving in the ack cycle are retained, never lost.
- event_valid = |event_data, registered (same cycle as event_data).
- en low: counters, stable, pulses and event_data held at 0; synchronizer keeps sampling. On en rising, a held button is accepted after DEBOUNCE_CNT cycles and generates a press.
- Multiple bits changing together are independent; several pulse bits may assert in one cycle.

## Timing
- Reset (rst high at clk edge): synchronizer flops, counters, state_out, press_pulse, release_pulse, event_data, event_valid all 0. Reset mid-debounce discards the partial count.
- Latency: pin held at new value from before edge 1 → sync_q changes after edge 2 → state_out and pulse after edge DEBOUNCE_CNT+2.
- Pin bounces shorter than DEBOUNCE_CNT cycles (after synchronization) produce no output change.
- event_data/event_valid update one edge after press_pulse is high; event_valid falls the edge after event_ack unless a press pulse coincides.
- No combinational path from any input to any output.

## Structure
- Shared package periph_pkg: DEFAULT_DEBOUNCE_CNT constant (50000) and board pin-count constants shared with the LED controller.
- Sub-module debounce_bit: synchronizer + counter + stable flop + edge pulses for one bit; parameters DEBOUNCE_CNT, CNT_W; instantiated N_INPUTS times in a generate loop. Event register and handshake live in the top.

## Test plan
(Run with DEBOUNCE_CNT=4, N_INPUTS=8.)
- Reset: assert rst with in_from_pin=8'h00 → all outputs 0 during and the cycle after reset.
- Clean press: in_from_pin bit0 1→0 held → state_out[0]=1 and press_pulse=8'h01 for one cycle after edge 6; event_data=8'h01, event_valid=1 one edge later.
- Bounce: bit3 toggled low 3 cycles, high 1, low held → no pulse until 4 consecutive synchronized low cycles; exactly one press_pulse=8'h08.
- Ack/press collision: event_data=8'h01, assert event_ack in the same cycle press_pulse=8'h04 → event_data=8'h04, event_valid stays 1.
- Release and multi-bit: bits 1 and 2 released together → release_pulse=8'h06 one cycle, state_out bits clear, event_data unchanged.
- Enable: bit5 held pressed, en low → all outputs 0; en high → press_pulse=8'h20 after 4 cycles.
